// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive controller.
// The optional parity path is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

    // Frame sequencing states, 3-bit encoding.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Oversampling ratios the receiver accepts.
    localparam logic [5:0] PRS_8  = 6'd8;
    localparam logic [5:0] PRS_16 = 6'd16;
    localparam logic [5:0] PRS_32 = 6'd32;

    // True when the prescale value is one of the supported ratios.
    function automatic logic prs_legal(input logic [5:0] prs);
        return (prs == PRS_8) || (prs == PRS_16) || (prs == PRS_32);
    endfunction

endpackage

// File: rtl/uart_rx_ctrl_edge_bit_counter.sv
// Oversample edge counter and frame bit counter for uart_rx_ctrl.
// Both counters sit at zero while idle. While running, the edge index wraps
// at prescale-1 and each wrap advances the bit index. Module: edge_bit_counter.
module edge_bit_counter (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_run,
    input  logic       i_clear,
    input  logic [5:0] i_prs,
    output logic [4:0] o_edge_cnt,
    output logic [3:0] o_bit_cnt,
    output logic       o_bit_end
);

    logic [4:0] r_edge_cnt;
    logic [3:0] r_bit_cnt;

    // Last oversample edge of the current bit.
    assign o_bit_end  = i_run && ({1'b0, r_edge_cnt} == (i_prs - 6'd1));
    assign o_edge_cnt = r_edge_cnt;
    assign o_bit_cnt  = r_bit_cnt;

    // Advance edge/bit indices while a frame is in progress, otherwise park at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (!i_run || i_clear) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= '0;
        end else if (o_bit_end) begin
            r_edge_cnt <= '0;
            r_bit_cnt  <= r_bit_cnt + 4'd1;
        end else begin
            r_edge_cnt <= r_edge_cnt + 5'd1;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: sequences start, data, optional parity and stop
// bits from the sampler's majority-voted bit, assembles the word LSB-first
// and flags parity/stop errors. Parity support is built only when the macro
// UART_RX_PARITY_EN is defined; otherwise par_en/par_typ are ignored and
// par_err is tied low.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic [5:0]            prescale,
    input  logic                  par_en,
    input  logic                  par_typ,
    input  logic                  sampled_bit,
    output logic                  dat_samp_en,
    output logic [4:0]            edge_cnt,
    output logic [3:0]            bit_cnt,
    output logic [DATA_WIDTH-1:0] p_data,
    output logic                  data_valid,
    output logic                  par_err,
    output logic                  stp_err
);

    // Bit index of the final data bit (start bit is index 0).
    localparam logic [3:0] LAST_DATA_BIT = 4'(DATA_WIDTH);

    rx_state_t             r_state;
    logic [5:0]            r_prs_q;
    logic                  r_samp_en;
    logic [DATA_WIDTH-1:0] r_p_data;
    logic                  r_valid;
    logic                  r_stp_err;

    logic [4:0]            w_edge_cnt;
    logic [3:0]            w_bit_cnt;
    logic                  w_bit_end;
    logic                  w_run;
    logic                  w_clear;

    // Counters run in every non-idle state and are cleared on the cycle that
    // returns to IDLE so they already read zero in the IDLE cycle.
    assign w_run   = (r_state != IDLE);
    assign w_clear = w_bit_end && (((r_state == START) && sampled_bit) || (r_state == STOP));

    edge_bit_counter u_edge_bit_counter (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_run      (w_run),
        .i_clear    (w_clear),
        .i_prs      (r_prs_q),
        .o_edge_cnt (w_edge_cnt),
        .o_bit_cnt  (w_bit_cnt),
        .o_bit_end  (w_bit_end)
    );

`ifdef UART_RX_PARITY_EN
    logic r_par_err;
    logic r_par_en_q;
    logic r_par_typ_q;

    // Frame sequencer with registered outputs (parity-capable build).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_prs_q     <= PRS_8;
            r_samp_en   <= 1'b0;
            r_p_data    <= '0;
            r_valid     <= 1'b0;
            r_stp_err   <= 1'b0;
            r_par_err   <= 1'b0;
            r_par_en_q  <= 1'b0;
            r_par_typ_q <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!rx_in && prs_legal(prescale)) begin
                        r_state   <= START;
                        r_prs_q   <= prescale;
                        r_samp_en <= 1'b1;
                        r_stp_err <= 1'b0;
                        r_par_err <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        if (!sampled_bit) begin
                            r_state     <= DATA;
                            r_par_en_q  <= par_en;
                            r_par_typ_q <= par_typ;
                        end else begin
                            r_state   <= IDLE;
                            r_samp_en <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_p_data <= {sampled_bit, r_p_data[DATA_WIDTH-1:1]};
                        if (w_bit_cnt == LAST_DATA_BIT) begin
                            r_state <= r_par_en_q ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_bit_end) begin
                        r_par_err <= sampled_bit ^ (^r_p_data) ^ r_par_typ_q;
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_stp_err <= ~sampled_bit;
                        r_valid   <= sampled_bit && !r_par_err;
                        r_state   <= IDLE;
                        r_samp_en <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_samp_en <= 1'b0;
                end
            endcase
        end
    end

    assign par_err = r_par_err;
`else
    // Parity configuration inputs have no effect in this build.
    logic w_unused_cfg;
    assign w_unused_cfg = par_en ^ par_typ;

    // Frame sequencer with registered outputs (no-parity build).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_prs_q   <= PRS_8;
            r_samp_en <= 1'b0;
            r_p_data  <= '0;
            r_valid   <= 1'b0;
            r_stp_err <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (!rx_in && prs_legal(prescale)) begin
                        r_state   <= START;
                        r_prs_q   <= prescale;
                        r_samp_en <= 1'b1;
                        r_stp_err <= 1'b0;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        if (!sampled_bit) begin
                            r_state <= DATA;
                        end else begin
                            r_state   <= IDLE;
                            r_samp_en <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_p_data <= {sampled_bit, r_p_data[DATA_WIDTH-1:1]};
                        if (w_bit_cnt == LAST_DATA_BIT) begin
                            r_state <= STOP;
                        end
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_stp_err <= ~sampled_bit;
                        r_valid   <= sampled_bit;
                        r_state   <= IDLE;
                        r_samp_en <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= IDLE;
                    r_samp_en <= 1'b0;
                end
            endcase
        end
    end

    assign par_err = 1'b0;
`endif

    assign dat_samp_en = r_samp_en;
    assign edge_cnt    = w_edge_cnt;
    assign bit_cnt     = w_bit_cnt;
    assign p_data      = r_p_data;
    assign data_valid  = r_valid;
    assign stp_err     = r_stp_err;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl. Expected frame outcomes are queued as
// frames are driven and compared when the receiver drops dat_samp_en.
// Expectations follow UART_RX_PARITY_EN the same way the design does.
module tb_uart_rx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;
    logic       sampled_bit;
    logic       dat_samp_en;
    logic [4:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic [7:0] p_data;
    logic       data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx_ctrl #(.DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .dat_samp_en (dat_samp_en),
        .edge_cnt    (edge_cnt),
        .bit_cnt     (bit_cnt),
        .p_data      (p_data),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  data;
        logic        valid;
        logic        perr;
        logic        serr;
        int unsigned len;
        int unsigned c0;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned n_checks = 0;
    int unsigned n_errors = 0;
    int unsigned cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Clean line: the sampler's vote equals the line level.
    task automatic set_line(input logic b);
        rx_in       = b;
        sampled_bit = b;
    endtask

    // Drive one frame, queueing the outcome the receiver should report.
    task automatic send_frame(input logic [5:0] prs, input logic [7:0] d,
                              input logic pen, input logic ptyp, input logic pbit,
                              input logic stop_b, input logic chk_clear);
        exp_t        e;
        int unsigned nbits;
        prescale = prs;
        par_en   = pen;
        par_typ  = ptyp;
        e.c0     = cyc;
        e.data   = d;
`ifdef UART_RX_PARITY_EN
        e.perr = pen && (pbit != ((^d) ^ ptyp));
        e.serr = ~stop_b;
        nbits  = pen ? 11 : 10;
`else
        e.perr = 1'b0;
        e.serr = pen ? ~pbit : ~stop_b;
        nbits  = 10;
`endif
        e.valid = !e.perr && !e.serr;
        e.len   = 1 + nbits * prs;
        sb_q.push_back(e);
        set_line(1'b0);
        for (int i = 0; i <= int'(prs); i++) begin
            tick();
            if (i == 0 && chk_clear) begin
                check("err_clear_stp", stp_err, 0);
                check("err_clear_par", par_err, 0);
                check("samp_en_start", dat_samp_en, 1);
            end
        end
        for (int b = 0; b < 8; b++) begin
            set_line(d[b]);
            repeat (prs) tick();
        end
        if (pen) begin
            set_line(pbit);
            repeat (prs) tick();
        end
        set_line(stop_b);
        repeat (prs) tick();
        set_line(1'b1);
        repeat (3) tick();
    endtask

    // Monitor: a frame ends when the sampler enable drops.
    initial begin : monitor
        logic        prev_se;
        int unsigned dv_run;
        exp_t        e;
        prev_se = 1'b0;
        dv_run  = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_se = 1'b0;
                dv_run  = 0;
            end else begin
                if (data_valid) begin
                    dv_run++;
                end else begin
                    if (dv_run != 0) check("dv_width", dv_run, 1);
                    dv_run = 0;
                end
                if (prev_se && !dat_samp_en) begin
                    if (sb_q.size() == 0) begin
                        check("sb_unexpected_end", sb_q.size(), 1);
                    end else begin
                        e = sb_q.pop_front();
                        check("frame_len", cyc - e.c0, e.len);
                        check("data_valid", data_valid, e.valid);
                        check("par_err", par_err, e.perr);
                        check("stp_err", stp_err, e.serr);
                        if (e.valid) check("p_data", p_data, e.data);
                    end
                end
                prev_se = dat_samp_en;
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        exp_t        g;
        int unsigned n;
        int unsigned se_seen;
        int unsigned cnt_seen;

        rst_n = 1'b0;
        set_line(1'b1);
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_samp_en", dat_samp_en, 0);
        check("rst_edge_cnt", edge_cnt, 0);
        check("rst_bit_cnt", bit_cnt, 0);
        check("rst_p_data", p_data, 0);
        check("rst_valid", data_valid, 0);
        check("rst_errs", {par_err, stp_err}, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Plain 8N1 at x8.
        send_frame(6'd8, 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        // Even parity with a wrong parity bit.
        send_frame(6'd16, 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
        // Odd parity with a correct parity bit.
        send_frame(6'd16, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        // Broken stop bit at x32, then a good frame that must clear stp_err.
        send_frame(6'd32, 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        send_frame(6'd32, 8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        // Two-cycle glitch: START is abandoned after one bit time.
        prescale = 6'd8;
        g.c0 = cyc; g.data = 8'h00; g.valid = 1'b0; g.perr = 1'b0; g.serr = 1'b0;
        g.len = 1 + 8;
        sb_q.push_back(g);
        set_line(1'b0);
        repeat (2) tick();
        set_line(1'b1);
        repeat (12) tick();

        // Reset in the middle of a frame.
        prescale = 6'd8;
        set_line(1'b0);
        repeat (9) tick();
        set_line(1'b1);
        n = 0;
        while (bit_cnt != 4'd4 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rst_wait_bitcnt", bit_cnt, 4);
        check("midframe_p_data_nz", (p_data != 8'h00), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_samp_en", dat_samp_en, 0);
        check("mrst_edge_cnt", edge_cnt, 0);
        check("mrst_bit_cnt", bit_cnt, 0);
        check("mrst_p_data", p_data, 0);
        check("mrst_valid", data_valid, 0);
        check("mrst_errs", {par_err, stp_err}, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) tick();
        send_frame(6'd8, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // Illegal prescale: a held-low line must not start a frame.
        prescale = 6'd12;
        set_line(1'b0);
        se_seen  = 0;
        cnt_seen = 0;
        repeat (40) begin
            tick();
            if (dat_samp_en) se_seen++;
            if (edge_cnt != 0 || bit_cnt != 0) cnt_seen++;
        end
        check("illegal_prs_samp_en", se_seen, 0);
        check("illegal_prs_counters", cnt_seen, 0);
        set_line(1'b1);
        repeat (2) tick();

        // Recovery with a legal ratio afterwards.
        send_frame(6'd16, 8'hC3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        repeat (5) tick();
        check("sb_empty", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
